hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 57 +++++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: stage-state inputs and control outputs between the pipeline
// datapath (master) and the hazard control block (slave).
// HAZARD_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
   logic       in_IDEX_MemRead;
   logic [4:0] in_IDEX_WriteRegister;
   logic [4:0] in_IDEX_Rs;
   logic [4:0] in_IDEX_Rt;
   logic [4:0] in_IFID_Rs;
   logic [4:0] in_IFID_Rt;
   logic       in_IFID_UsesRt;
   logic       in_EX_BranchTaken;
   logic       in_EX_Jump;
   logic       in_EXMEM_RegWrite;
   logic [4:0] in_EXMEM_WriteRegister;
   logic       in_MEMWB_RegWrite;
   logic [4:0] in_MEMWB_WriteRegister;
   logic       out_PCWrite;
   logic       out_IFIDWrite;
   logic       out_IFIDFlush;
   logic       out_IDEXBubble;
   logic [1:0] out_ForwardA;
   logic [1:0] out_ForwardB;
   logic       out_Stalling;
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] out_StallCnt;
   logic [CNT_W-1:0] out_FlushCnt;
`endif

   modport master (
      output in_IDEX_MemRead, in_IDEX_WriteRegister, in_IDEX_Rs, in_IDEX_Rt,
             in_IFID_Rs, in_IFID_Rt, in_IFID_UsesRt, in_EX_BranchTaken, in_EX_Jump,
             in_EXMEM_RegWrite, in_EXMEM_WriteRegister,
             in_MEMWB_RegWrite, in_MEMWB_WriteRegister,
      input  out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXBubble,
             out_ForwardA, out_ForwardB, out_Stalling
`ifdef HAZARD_PERF_CNT_EN
           , out_StallCnt, out_FlushCnt
`endif
   );

   modport slave (
      input  in_IDEX_MemRead, in_IDEX_WriteRegister, in_IDEX_Rs, in_IDEX_Rt,
             in_IFID_Rs, in_IFID_Rt, in_IFID_UsesRt, in_EX_BranchTaken, in_EX_Jump,
             in_EXMEM_RegWrite, in_EXMEM_WriteRegister,
             in_MEMWB_RegWrite, in_MEMWB_WriteRegister,
      output out_PCWrite, out_IFIDWrite, out_IFIDFlush, out_IDEXBubble,
             out_ForwardA, out_ForwardB, out_Stalling
`ifdef HAZARD_PERF_CNT_EN
           , out_StallCnt, out_FlushCnt
`endif
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch/jump squash and EX operand forwarding
// control for a 5-stage pipeline. A load-use hazard stalls fetch/decode for
// LOAD_USE_STALL_CYCLES cycles (1..3); a redirect resolved in EX always wins.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
   parameter int LOAD_USE_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
 , parameter int CNT_W = 16
`endif
) (
   input  logic         clk,
   input  logic         reset_n,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   // The first stall cycle is spent in RUN, so STALL covers the remainder.
   localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       redirect;
   logic       ld_use;

   assign redirect = bus.in_EX_BranchTaken | bus.in_EX_Jump;
   assign ld_use   = bus.in_IDEX_MemRead && (bus.in_IDEX_WriteRegister != 5'd0) &&
                     ((bus.in_IDEX_WriteRegister == bus.in_IFID_Rs) ||
                      (bus.in_IFID_UsesRt && (bus.in_IDEX_WriteRegister == bus.in_IFID_Rt)));

   // State register and remaining-stall counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: redirect aborts everything; STALL ignores new hazards.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         RUN: begin
            if (redirect) begin
               state_nxt = RUN;
               cnt_nxt   = 2'd0;
            end else if (ld_use && (LOAD_USE_STALL_CYCLES > 1)) begin
               state_nxt = STALL;
               cnt_nxt   = STALL_INIT;
            end
         end
         STALL: begin
            if (redirect || (cnt == 2'd1)) begin
               state_nxt = RUN;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt   = cnt - 2'd1;
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // Pipeline control outputs; reset forces a held, flushed pipeline at once.
   always_comb begin
      bus.out_PCWrite    = 1'b1;
      bus.out_IFIDWrite  = 1'b1;
      bus.out_IFIDFlush  = 1'b0;
      bus.out_IDEXBubble = 1'b0;
      bus.out_Stalling   = (state == STALL);
      if (!reset_n) begin
         bus.out_PCWrite    = 1'b0;
         bus.out_IFIDWrite  = 1'b0;
         bus.out_IFIDFlush  = 1'b1;
         bus.out_IDEXBubble = 1'b1;
         bus.out_Stalling   = 1'b0;
      end else if (redirect) begin
         bus.out_IFIDFlush  = 1'b1;
         bus.out_IDEXBubble = 1'b1;
      end else if ((state == STALL) || ld_use) begin
         bus.out_PCWrite    = 1'b0;
         bus.out_IFIDWrite  = 1'b0;
         bus.out_IDEXBubble = 1'b1;
      end
   end

   // Operand forwarding selects; EX/MEM is newer so it wins, r0 never forwards.
   always_comb begin
      bus.out_ForwardA = 2'b00;
      bus.out_ForwardB = 2'b00;
      if (reset_n) begin
         if (bus.in_EXMEM_RegWrite && (bus.in_EXMEM_WriteRegister != 5'd0) &&
             (bus.in_EXMEM_WriteRegister == bus.in_IDEX_Rs))
            bus.out_ForwardA = 2'b10;
         else if (bus.in_MEMWB_RegWrite && (bus.in_MEMWB_WriteRegister != 5'd0) &&
                  (bus.in_MEMWB_WriteRegister == bus.in_IDEX_Rs))
            bus.out_ForwardA = 2'b01;
         if (bus.in_EXMEM_RegWrite && (bus.in_EXMEM_WriteRegister != 5'd0) &&
             (bus.in_EXMEM_WriteRegister == bus.in_IDEX_Rt))
            bus.out_ForwardB = 2'b10;
         else if (bus.in_MEMWB_RegWrite && (bus.in_MEMWB_WriteRegister != 5'd0) &&
                  (bus.in_MEMWB_WriteRegister == bus.in_IDEX_Rt))
            bus.out_ForwardB = 2'b01;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating counts of stalled (PC held) and flushed cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.out_StallCnt <= '0;
         bus.out_FlushCnt <= '0;
      end else begin
         if (!bus.out_PCWrite && (bus.out_StallCnt != '1))
            bus.out_StallCnt <= bus.out_StallCnt + CNT_W'(1);
         if (bus.out_IFIDFlush && (bus.out_FlushCnt != '1))
            bus.out_FlushCnt <= bus.out_FlushCnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test of hazard_ctrl with one instance per stall
// depth (1 and 3) sharing the same stimulus. Counter checks use CNT_W=2 and
// are compiled only when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic       memread = 1'b0, usesrt = 1'b0, br = 1'b0, jmp = 1'b0;
   logic       exmem_rw = 1'b0, memwb_rw = 1'b0;
   logic [4:0] idex_wr = '0, idex_rs = '0, idex_rt = '0;
   logic [4:0] ifid_rs = '0, ifid_rt = '0, exmem_wr = '0, memwb_wr = '0;

   int nchecks = 0;
   int nerrors = 0;

`ifdef HAZARD_PERF_CNT_EN
   hazard_ctrl_if #(.CNT_W(2)) bus1 ();
   hazard_ctrl_if #(.CNT_W(2)) bus3 ();
   hazard_ctrl #(.LOAD_USE_STALL_CYCLES(1), .CNT_W(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
   hazard_ctrl #(.LOAD_USE_STALL_CYCLES(3), .CNT_W(2)) u3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
`else
   hazard_ctrl_if bus1 ();
   hazard_ctrl_if bus3 ();
   hazard_ctrl #(.LOAD_USE_STALL_CYCLES(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
   hazard_ctrl #(.LOAD_USE_STALL_CYCLES(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
`endif

   assign bus1.in_IDEX_MemRead        = memread;
   assign bus1.in_IDEX_WriteRegister  = idex_wr;
   assign bus1.in_IDEX_Rs             = idex_rs;
   assign bus1.in_IDEX_Rt             = idex_rt;
   assign bus1.in_IFID_Rs             = ifid_rs;
   assign bus1.in_IFID_Rt             = ifid_rt;
   assign bus1.in_IFID_UsesRt         = usesrt;
   assign bus1.in_EX_BranchTaken      = br;
   assign bus1.in_EX_Jump             = jmp;
   assign bus1.in_EXMEM_RegWrite      = exmem_rw;
   assign bus1.in_EXMEM_WriteRegister = exmem_wr;
   assign bus1.in_MEMWB_RegWrite      = memwb_rw;
   assign bus1.in_MEMWB_WriteRegister = memwb_wr;

   assign bus3.in_IDEX_MemRead        = memread;
   assign bus3.in_IDEX_WriteRegister  = idex_wr;
   assign bus3.in_IDEX_Rs             = idex_rs;
   assign bus3.in_IDEX_Rt             = idex_rt;
   assign bus3.in_IFID_Rs             = ifid_rs;
   assign bus3.in_IFID_Rt             = ifid_rt;
   assign bus3.in_IFID_UsesRt         = usesrt;
   assign bus3.in_EX_BranchTaken      = br;
   assign bus3.in_EX_Jump             = jmp;
   assign bus3.in_EXMEM_RegWrite      = exmem_rw;
   assign bus3.in_EXMEM_WriteRegister = exmem_wr;
   assign bus3.in_MEMWB_RegWrite      = memwb_rw;
   assign bus3.in_MEMWB_WriteRegister = memwb_wr;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      memread = 1'b0; usesrt = 1'b0; br = 1'b0; jmp = 1'b0;
      exmem_rw = 1'b0; memwb_rw = 1'b0;
      idex_wr = '0; idex_rs = '0; idex_rt = '0;
      ifid_rs = '0; ifid_rt = '0; exmem_wr = '0; memwb_wr = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      #1;
      chk("rst_pcwrite",  {3'b0, bus1.out_PCWrite},    4'h0);
      chk("rst_ifidwr",   {3'b0, bus1.out_IFIDWrite},  4'h0);
      chk("rst_flush",    {3'b0, bus1.out_IFIDFlush},  4'h1);
      chk("rst_bubble",   {3'b0, bus1.out_IDEXBubble}, 4'h1);
      chk("rst_fwda",     {2'b0, bus1.out_ForwardA},   4'h0);
      chk("rst_stalling", {3'b0, bus3.out_Stalling},   4'h0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("run_pcwrite", {3'b0, bus1.out_PCWrite},   4'h1);
      chk("run_flush",   {3'b0, bus1.out_IFIDFlush}, 4'h0);
      chk("run_bubble",  {3'b0, bus1.out_IDEXBubble}, 4'h0);

      // load-use on rs: N=1 stalls one cycle, N=3 three cycles
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8;
      #1;
      chk("lu1_pcwrite", {3'b0, bus1.out_PCWrite},    4'h0);
      chk("lu1_ifidwr",  {3'b0, bus1.out_IFIDWrite},  4'h0);
      chk("lu1_bubble",  {3'b0, bus1.out_IDEXBubble}, 4'h1);
      chk("lu1_flush",   {3'b0, bus1.out_IFIDFlush},  4'h0);
      chk("lu3_c1_stalling", {3'b0, bus3.out_Stalling}, 4'h0);
      tick();
      clear_in();
      #1;
      chk("lu1_after_pcwrite", {3'b0, bus1.out_PCWrite}, 4'h1);
      chk("lu3_c2_pcwrite",    {3'b0, bus3.out_PCWrite}, 4'h0);
      chk("lu3_c2_stalling",   {3'b0, bus3.out_Stalling}, 4'h1);
      tick();
      chk("lu3_c3_pcwrite",    {3'b0, bus3.out_PCWrite}, 4'h0);
      chk("lu3_c3_stalling",   {3'b0, bus3.out_Stalling}, 4'h1);
      tick();
      chk("lu3_end_pcwrite",   {3'b0, bus3.out_PCWrite}, 4'h1);
      chk("lu3_end_stalling",  {3'b0, bus3.out_Stalling}, 4'h0);

      // destination r0 never creates a hazard
      memread = 1'b1; idex_wr = 5'd0; ifid_rs = 5'd0;
      #1;
      chk("lu_r0_pcwrite", {3'b0, bus1.out_PCWrite}, 4'h1);
      tick();
      clear_in();

      // load-use on rt with UsesRt=1 (N=3)
      memread = 1'b1; idex_wr = 5'd9; ifid_rt = 5'd9; usesrt = 1'b1;
      #1;
      chk("rt_c1_pcwrite", {3'b0, bus3.out_PCWrite}, 4'h0);
      tick();
      clear_in();
      #1;
      chk("rt_c2_stalling", {3'b0, bus3.out_Stalling}, 4'h1);
      tick();
      chk("rt_c3_pcwrite", {3'b0, bus3.out_PCWrite}, 4'h0);
      tick();
      chk("rt_end_pcwrite", {3'b0, bus3.out_PCWrite}, 4'h1);

      // rt match without UsesRt: no stall
      memread = 1'b1; idex_wr = 5'd9; ifid_rt = 5'd9; usesrt = 1'b0;
      #1;
      chk("rt_nouse_pcwrite", {3'b0, bus3.out_PCWrite}, 4'h1);
      tick();
      clear_in();
      #1;
      chk("rt_nouse_stalling", {3'b0, bus3.out_Stalling}, 4'h0);

      // redirect beats load-use in the same cycle
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8; br = 1'b1;
      #1;
      chk("redir_flush",   {3'b0, bus3.out_IFIDFlush},  4'h1);
      chk("redir_pcwrite", {3'b0, bus3.out_PCWrite},    4'h1);
      chk("redir_bubble",  {3'b0, bus3.out_IDEXBubble}, 4'h1);
      tick();
      clear_in();
      #1;
      chk("redir_next_stalling", {3'b0, bus3.out_Stalling}, 4'h0);
      chk("redir_next_pcwrite",  {3'b0, bus3.out_PCWrite},  4'h1);

      // jump on stall cycle 2 aborts the stall
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8;
      tick();
      clear_in();
      jmp = 1'b1;
      #1;
      chk("jstall_flush",   {3'b0, bus3.out_IFIDFlush}, 4'h1);
      chk("jstall_pcwrite", {3'b0, bus3.out_PCWrite},   4'h1);
      tick();
      clear_in();
      #1;
      chk("jstall_next_stalling", {3'b0, bus3.out_Stalling}, 4'h0);
      chk("jstall_next_pcwrite",  {3'b0, bus3.out_PCWrite},  4'h1);
      chk("jstall_next_flush",    {3'b0, bus3.out_IFIDFlush}, 4'h0);

      // forwarding
      exmem_rw = 1'b1; exmem_wr = 5'd5; memwb_rw = 1'b1; memwb_wr = 5'd5; idex_rs = 5'd5;
      #1;
      chk("fwda_exmem", {2'b0, bus1.out_ForwardA}, 4'h2);
      exmem_rw = 1'b0;
      #1;
      chk("fwda_memwb", {2'b0, bus1.out_ForwardA}, 4'h1);
      exmem_rw = 1'b1; exmem_wr = 5'd7; idex_rt = 5'd7;
      #1;
      chk("fwdb_exmem", {2'b0, bus1.out_ForwardB}, 4'h2);
      chk("fwda_memwb_with_b", {2'b0, bus1.out_ForwardA}, 4'h1);
      exmem_wr = 5'd0; memwb_wr = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
      #1;
      chk("fwda_r0", {2'b0, bus1.out_ForwardA}, 4'h0);
      chk("fwdb_r0", {2'b0, bus1.out_ForwardB}, 4'h0);
      clear_in();

      // mid-stall reset
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8;
      tick();
      clear_in();
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_pcwrite",  {3'b0, bus3.out_PCWrite},  4'h0);
      chk("midrst_flush",    {3'b0, bus3.out_IFIDFlush}, 4'h1);
      chk("midrst_stalling", {3'b0, bus3.out_Stalling}, 4'h0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("postrst_pcwrite",  {3'b0, bus3.out_PCWrite},  4'h1);
      chk("postrst_stalling", {3'b0, bus3.out_Stalling}, 4'h0);

`ifdef HAZARD_PERF_CNT_EN
      // saturating counters, CNT_W=2
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();
      chk("cnt_stall_zero", {2'b0, bus3.out_StallCnt}, 4'h0);
      chk("cnt_flush_zero", {2'b0, bus3.out_FlushCnt}, 4'h0);
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8;
      tick();
      clear_in();
      tick();
      chk("cnt_stall_two", {2'b0, bus3.out_StallCnt}, 4'h2);
      tick();
      chk("cnt_stall_three", {2'b0, bus3.out_StallCnt}, 4'h3);
      memread = 1'b1; idex_wr = 5'd8; ifid_rs = 5'd8;
      tick();
      clear_in();
      tick();
      tick();
      chk("cnt_stall_sat", {2'b0, bus3.out_StallCnt}, 4'h3);
      br = 1'b1;
      tick();
      chk("cnt_flush_one", {2'b0, bus3.out_FlushCnt}, 4'h1);
      tick();
      clear_in();
      tick();
      chk("cnt_flush_two", {2'b0, bus3.out_FlushCnt}, 4'h2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
